corrupt_sched: RTL
==================

CORRUPT_SCHED -- requirements
Module: corrupt_sched

Interface
REQ-001 The block SHALL have exactly one clock; reset SHALL be asynchronous and active-low.
REQ-002 i_clk  in  1  system clock; all state SHALL change on its rising edge.
REQ-003 i_rst_n  in  1  asynchronous active-low reset.
REQ-004 i_row_cnt  in  2  current frame row.
REQ-005 i_col_cnt  in  11  current frame column.
REQ-006 i_frame_data_valid  in  1  line byte valid.
REQ-007 i_sw_enable  in  1  hardware corruption switch; 1 = allowed.
REQ-008 i_mode  in  2  scheduling mode: 00 off, 01 continuous, 10 burst/gap, 11 single-shot.
REQ-009 i_burst_len  in  4  number of frames per burst; 0 SHALL be treated as 1.
REQ-010 i_gap_len  in  4  number of clean frames between bursts; 0 means back-to-back bursts.
REQ-011 i_seed_base  in  8  seed for the first burst.
REQ-012 i_trigger  in  1  single-cycle pulse that starts one burst in single-shot mode.
REQ-013 i_clr_stats  in  1  single-cycle pulse that clears o_corrupt_frames.
REQ-014 o_corrupt_en  out  1  corruption enable to the corruptor.
REQ-015 o_corrupt_seed  out  8  LFSR seed to the corruptor.
REQ-016 o_seed_load  out  1  one-cycle pulse; the corruptor SHALL reload its LFSR from o_corrupt_seed.
REQ-017 o_corrupt_frames  out  16  count of frames started while corrupting; saturating.
REQ-018 o_busy  out  1  high in any state except IDLE.

Function
REQ-019 A frame start (SOF) SHALL be i_frame_data_valid=1 with i_row_cnt=0 and i_col_cnt=0 in the same cycle.
REQ-020 The FSM SHALL have states IDLE, ARM, ON, and GAP.
REQ-021 IDLE->ARM: i_sw_enable=1 and i_mode is 01 or 10, or i_mode=11 and i_trigger=1.
REQ-022 On IDLE->ARM the block SHALL latch i_mode, i_burst_len, i_gap_len, and i_seed_base; later input changes SHALL be ignored until the block returns to IDLE.
REQ-023 ARM->ON on SOF: load the burst counter with the burst length, assert o_seed_load for 1 cycle, and set o_corrupt_en=1 from the next cycle.
REQ-024 In ON, each SOF SHALL increment o_corrupt_frames (saturating at 0xFFFF) and decrement the burst counter; the ON-entry SOF counts.
REQ-025 Continuous mode SHALL remain in ON indefinitely without decrementing.
REQ-026 In ON, when the burst counter reaches 0 at an SOF:
- burst mode with gap>0: go to GAP, load the gap counter, and deassert o_corrupt_en the next cycle;
- burst mode with gap=0: stay in ON, reload the burst counter, and reseed;
- single-shot mode: go to IDLE.
REQ-027 In GAP, each SOF SHALL decrement the gap counter; when it reaches 0 the block SHALL go to ON, applying the REQ-023 actions.
REQ-028 The seed SHALL be the latched base plus the burst index (first burst = base), modulo 256.
REQ-029 The seed SHALL update in the same cycle as o_seed_load.
REQ-030 i_sw_enable=0 or i_mode=00 in any state SHALL force IDLE the next cycle, with o_corrupt_en=0 mid-frame; this abort SHALL take priority over all other transitions.
REQ-031 i_trigger outside IDLE, or outside mode 11, SHALL be ignored.
REQ-032 i_clr_stats SHALL clear the counter.
REQ-033 When i_clr_stats coincides with a counting SOF, the counter SHALL read 1.
REQ-034 All outputs SHALL be registered.

Reset
REQ-035 While i_rst_n=0:
- the state SHALL be IDLE;
- o_corrupt_en, o_seed_load, and o_busy SHALL be 0;
- o_corrupt_seed and o_corrupt_frames SHALL be 0;
- all counters and latched configuration SHALL be 0.
REQ-036 Assertion of reset mid-burst SHALL drop o_corrupt_en asynchronously.
REQ-037 After reset release, the block SHALL wait in IDLE without requiring an SOF.

Structure
REQ-038 The package corrupt_pkg SHALL hold:
- the state encoding;
- the mode codes MODE_OFF, MODE_CONT, MODE_BURST, and MODE_SINGLE;
- the widths ROW_W=2, COL_W=11, SEED_W=8, and STAT_W=16.
REQ-039 SOF detection SHALL be a sub-module corrupt_sof_det (registered-free, combinational compare); everything else SHALL be flat.

Verification
REQ-040 Burst mode with burst=2, gap=1, base=0x5A, switch on:
- 3 bursts SHALL produce o_corrupt_en high for frames 1-2, 4-5, and 7-8;
- seeds SHALL be 0x5A, 0x5B, and 0x5C, each with one o_seed_load pulse;
- o_corrupt_frames SHALL read 6 at the frame-9 SOF.
REQ-041 Single-shot mode with burst=0 and one i_trigger:
- exactly 1 frame SHALL be corrupted, then o_busy=0;
- a second i_trigger during ON SHALL have no effect.
REQ-042 Continuous mode with base=0xFF:
- o_corrupt_en SHALL stay high for 10 frames;
- o_corrupt_frames SHALL read 10;
- i_clr_stats SHALL then make it read 0.
REQ-043 Burst mode with burst=3, gap=0, base=0xFE: the seed SHALL step 0xFE, 0xFF, 0x00 at SOFs 1, 4, and 7.
REQ-044 Dropping i_sw_enable at column 500 of frame 1 during ON SHALL give o_corrupt_en=0 the next cycle and the state IDLE.
REQ-045 Asserting i_rst_n=0 mid-GAP SHALL give all outputs 0 immediately; after release, the block SHALL re-arm and corrupt the first SOF with seed = base.

Source files
------------

// File: rtl/corrupt_pkg.sv
// Shared types and widths for the corruption scheduler: FSM encoding, mode codes, bus widths.
package corrupt_pkg;

   localparam int ROW_W  = 2;
   localparam int COL_W  = 11;
   localparam int SEED_W = 8;
   localparam int STAT_W = 16;
   localparam int CNT_W  = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARM  = 2'd1,
      ST_ON   = 2'd2,
      ST_GAP  = 2'd3
   } state_t;

   localparam logic [1:0] MODE_OFF    = 2'b00;
   localparam logic [1:0] MODE_CONT   = 2'b01;
   localparam logic [1:0] MODE_BURST  = 2'b10;
   localparam logic [1:0] MODE_SINGLE = 2'b11;

   // A zero burst length still corrupts one frame.
   function automatic logic [CNT_W-1:0] eff_burst(input logic [CNT_W-1:0] len);
      return (len == '0) ? CNT_W'(1) : len;
   endfunction

endpackage

// File: rtl/corrupt_sof_det.sv
// Frame-start detector: valid byte at row 0, column 0.
// Purely combinational, zero latency; no flow control.
module corrupt_sof_det
   import corrupt_pkg::*;
(
   input  logic             i_frame_data_valid,
   input  logic [ROW_W-1:0] i_row_cnt,
   input  logic [COL_W-1:0] i_col_cnt,
   output logic             o_sof
);

   assign o_sof = i_frame_data_valid && (i_row_cnt == '0) && (i_col_cnt == '0);

endmodule

// File: rtl/corrupt_sched.sv
// Schedules corruption bursts on frame boundaries and hands the corruptor a seed per burst.
// All outputs registered (one cycle after the triggering SOF); no backpressure, SOFs are never stalled.
module corrupt_sched
   import corrupt_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic [ROW_W-1:0]  i_row_cnt,
   input  logic [COL_W-1:0]  i_col_cnt,
   input  logic              i_frame_data_valid,
   input  logic              i_sw_enable,
   input  logic [1:0]        i_mode,
   input  logic [CNT_W-1:0]  i_burst_len,
   input  logic [CNT_W-1:0]  i_gap_len,
   input  logic [SEED_W-1:0] i_seed_base,
   input  logic              i_trigger,
   input  logic              i_clr_stats,
   output logic              o_corrupt_en,
   output logic [SEED_W-1:0] o_corrupt_seed,
   output logic              o_seed_load,
   output logic [STAT_W-1:0] o_corrupt_frames,
   output logic              o_busy
);

   state_t              state_q;
   logic [1:0]          mode_q;
   logic [CNT_W-1:0]    burst_len_q;
   logic [CNT_W-1:0]    gap_len_q;
   logic [SEED_W-1:0]   seed_base_q;
   logic [CNT_W-1:0]    burst_cnt_q;
   logic [CNT_W-1:0]    gap_cnt_q;
   logic [SEED_W-1:0]   burst_idx_q;
   logic                corrupt_en_q;
   logic [SEED_W-1:0]   seed_q;
   logic                seed_load_q;
   logic [STAT_W-1:0]   frames_q;
   logic                busy_q;

   logic sof;
   logic abort;
   logic arm_req;
   logic start_burst;
   logic count_frame;

   corrupt_sof_det u_sof_det (
      .i_frame_data_valid (i_frame_data_valid),
      .i_row_cnt          (i_row_cnt),
      .i_col_cnt          (i_col_cnt),
      .o_sof              (sof)
   );

   assign abort   = !i_sw_enable || (i_mode == MODE_OFF);
   assign arm_req = i_sw_enable &&
                    ((i_mode == MODE_CONT) || (i_mode == MODE_BURST) ||
                     ((i_mode == MODE_SINGLE) && i_trigger));

   // A new burst starts on the arming SOF, on an exhausted gap, or back-to-back in burst mode.
   always_comb begin
      start_burst = 1'b0;
      count_frame = 1'b0;
      if (!abort && sof) begin
         unique case (state_q)
            ST_ARM: start_burst = 1'b1;
            ST_ON: begin
               if (mode_q != MODE_CONT && burst_cnt_q == '0 &&
                   mode_q == MODE_BURST && gap_len_q == '0)
                  start_burst = 1'b1;
               count_frame = (mode_q == MODE_CONT) || (burst_cnt_q != '0);
            end
            ST_GAP:  start_burst = (gap_cnt_q <= CNT_W'(1));
            default: start_burst = 1'b0;
         endcase
         if (start_burst)
            count_frame = 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q      <= ST_IDLE;
         mode_q       <= MODE_OFF;
         burst_len_q  <= '0;
         gap_len_q    <= '0;
         seed_base_q  <= '0;
         burst_cnt_q  <= '0;
         gap_cnt_q    <= '0;
         burst_idx_q  <= '0;
         corrupt_en_q <= 1'b0;
         seed_q       <= '0;
         seed_load_q  <= 1'b0;
         frames_q     <= '0;
         busy_q       <= 1'b0;
      end else begin
         seed_load_q <= 1'b0;

         // Clear and count in one cycle leaves the counter at 1.
         if (count_frame)
            frames_q <= i_clr_stats ? STAT_W'(1) :
                        (frames_q == '1) ? frames_q : frames_q + STAT_W'(1);
         else if (i_clr_stats)
            frames_q <= '0;

         if (abort) begin
            state_q      <= ST_IDLE;
            corrupt_en_q <= 1'b0;
            busy_q       <= 1'b0;
         end else if (start_burst) begin
            state_q      <= ST_ON;
            burst_cnt_q  <= eff_burst(burst_len_q) - CNT_W'(1);
            seed_q       <= seed_base_q + burst_idx_q;
            burst_idx_q  <= burst_idx_q + SEED_W'(1);
            seed_load_q  <= 1'b1;
            corrupt_en_q <= 1'b1;
            busy_q       <= 1'b1;
         end else begin
            unique case (state_q)
               ST_IDLE: begin
                  if (arm_req) begin
                     state_q     <= ST_ARM;
                     mode_q      <= i_mode;
                     burst_len_q <= i_burst_len;
                     gap_len_q   <= i_gap_len;
                     seed_base_q <= i_seed_base;
                     burst_idx_q <= '0;
                     busy_q      <= 1'b1;
                  end
               end
               ST_ON: begin
                  if (sof && mode_q != MODE_CONT) begin
                     if (burst_cnt_q != '0) begin
                        burst_cnt_q <= burst_cnt_q - CNT_W'(1);
                     end else if (mode_q == MODE_SINGLE) begin
                        state_q      <= ST_IDLE;
                        corrupt_en_q <= 1'b0;
                        busy_q       <= 1'b0;
                     end else begin
                        state_q      <= ST_GAP;
                        gap_cnt_q    <= gap_len_q;
                        corrupt_en_q <= 1'b0;
                     end
                  end
               end
               ST_GAP: begin
                  if (sof)
                     gap_cnt_q <= gap_cnt_q - CNT_W'(1);
               end
               default: state_q <= state_q;
            endcase
         end
      end
   end

   assign o_corrupt_en     = corrupt_en_q;
   assign o_corrupt_seed   = seed_q;
   assign o_seed_load      = seed_load_q;
   assign o_corrupt_frames = frames_q;
   assign o_busy           = busy_q;

endmodule
